// File: rtl/universal_shift_reg.sv
// Universal shift register: parallel load, hold, shift/rotate L/R in STEP-bit steps,
// single-step or counted burst with busy/done. Define ARITH_SHIFT_EN to make op 101 an ASR.
module universal_shift_reg #(
  parameter int BITS  = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [BITS-1:0]  data,
  input  logic             Load,
  input  logic [2:0]       op,
  input  logic             step,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [STEP-1:0]  SinL,
  input  logic [STEP-1:0]  SinR,
  output logic [BITS-1:0]  out,
  output logic [STEP-1:0]  soutL,
  output logic [STEP-1:0]  soutR,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_SHL = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
`ifdef ARITH_SHIFT_EN
  localparam logic [2:0] OP_ASR = 3'b101;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic [2:0]       op_lat;

  function automatic logic [BITS-1:0] apply_op(
    input logic [BITS-1:0] v,
    input logic [2:0]      o,
    input logic [STEP-1:0] sl,
    input logic [STEP-1:0] sr
  );
    logic [BITS-1:0] r;
    case (o)
      OP_SHL:  r = {v[BITS-1-STEP:0], sl};
      OP_SHR:  r = {sr, v[BITS-1:STEP]};
      OP_ROL:  r = {v[BITS-1-STEP:0], v[BITS-1 -: STEP]};
      OP_ROR:  r = {v[STEP-1:0], v[BITS-1:STEP]};
`ifdef ARITH_SHIFT_EN
      OP_ASR:  r = {{STEP{v[BITS-1]}}, v[BITS-1:STEP]};
`endif
      default: r = v;
    endcase
    return r;
  endfunction

  assign soutL = out[BITS-1 -: STEP];
  assign soutR = out[STEP-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      out    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      state  <= IDLE;
      rem    <= '0;
      op_lat <= 3'b000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (Load) begin
            out <= data;
          end else if (start) begin
            // A zero-length burst still completes, so it reports done straight away.
            if (count != '0) begin
              op_lat <= op;
              rem    <= count;
              busy   <= 1'b1;
              state  <= RUN;
            end else begin
              done <= 1'b1;
            end
          end else if (step) begin
            out <= apply_op(out, op, SinL, SinR);
          end
        end
        RUN: begin
          if (Load) begin
            out   <= data;
            busy  <= 1'b0;
            rem   <= '0;
            state <= IDLE;
          end else begin
            out <= apply_op(out, op_lat, SinL, SinR);
            rem <= rem - CNT_W'(1);
            if (rem == CNT_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: vector table, hand-written corner
// sequences, and randomized traffic against an integer reference model.
module tb_universal_shift_reg;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] data;
  logic       Load;
  logic [2:0] op;
  logic       step;
  logic       start;
  logic [3:0] count;
  logic [0:0] SinL;
  logic [0:0] SinR;
  logic [7:0] out;
  logic [0:0] soutL;
  logic [0:0] soutR;
  logic       busy;
  logic       done;

  logic [15:0] data16;
  logic        load16;
  logic [2:0]  op16;
  logic        step16;
  logic [3:0]  sinl16;
  logic [3:0]  sinr16;
  logic [15:0] out16;
  logic [3:0]  soutl16;
  logic [3:0]  soutr16;
  logic        busy16;
  logic        done16;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  universal_shift_reg #(.BITS(8), .STEP(1), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .data(data), .Load(Load), .op(op), .step(step),
    .start(start), .count(count), .SinL(SinL), .SinR(SinR), .out(out),
    .soutL(soutL), .soutR(soutR), .busy(busy), .done(done)
  );

  universal_shift_reg #(.BITS(16), .STEP(4), .CNT_W(4)) dut16 (
    .CLK(CLK), .RST(RST), .data(data16), .Load(load16), .op(op16), .step(step16),
    .start(1'b0), .count(4'd0), .SinL(sinl16), .SinR(sinr16), .out(out16),
    .soutL(soutl16), .soutR(soutr16), .busy(busy16), .done(done16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    Load = 1'b0; data = 8'h00; op = 3'b000; step = 1'b0; start = 1'b0;
    count = 4'd0; SinL = 1'b0; SinR = 1'b0;
  endtask

  // Reference model: 8-bit register, 1-bit steps, computed with integer arithmetic.
  localparam int B    = 8;
  localparam int S    = 1;
  localparam int MASK = (1 << B) - 1;

  int m_out, m_left, m_op, m_done;

  function automatic int ref_shift(input int v, input int o, input int sl, input int sr);
    int sv;
    case (o)
      1: return ((v << S) | sl) & MASK;
      2: return (v >> S) | (sr << (B - S));
      3: return ((v << S) | (v >> (B - S))) & MASK;
      4: return (v >> S) | ((v << (B - S)) & MASK);
`ifdef ARITH_SHIFT_EN
      5: begin
        sv = (v >= (1 << (B - 1))) ? v - (1 << B) : v;
        return (sv >>> S) & MASK;
      end
`endif
      default: return v;
    endcase
  endfunction

  task automatic model_edge;
    int nd;
    if (RST) begin
      m_out = 0; m_left = 0; m_op = 0; m_done = 0;
    end else begin
      nd = 0;
      if (m_left == 0) begin
        if (Load) m_out = int'(data);
        else if (start) begin
          if (count != 0) begin m_left = int'(count); m_op = int'(op); end
          else nd = 1;
        end else if (step) m_out = ref_shift(m_out, int'(op), int'(SinL), int'(SinR));
      end else begin
        if (Load) begin m_out = int'(data); m_left = 0; end
        else begin
          m_out = ref_shift(m_out, m_op, int'(SinL), int'(SinR));
          m_left--;
          if (m_left == 0) nd = 1;
        end
      end
      m_done = nd;
    end
  endtask

  typedef struct {
    logic       ld;
    logic [7:0] d;
    logic [2:0] o;
    logic       st;
    logic       go;
    logic [3:0] cnt;
    logic       sl;
    logic       sr;
    logic [7:0] e_out;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tbl[17];
  logic [7:0] exp6;

  initial begin
    tbl[0]  = '{1'b1, 8'h81, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 3'd3, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h06, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h0F, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 8'h3F, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'hF0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 3'd2, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h78, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h1E, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 3'd2, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0};

    idle_inputs();
    data16 = 16'h0; load16 = 1'b0; op16 = 3'd0; step16 = 1'b0; sinl16 = 4'h0; sinr16 = 4'h0;

    // Reset state
    RST = 1'b1;
    tick();
    check("reset out", out, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset out16", out16, 0);
    RST = 1'b0;

    // Vector table
    for (int i = 0; i < 17; i++) begin
      Load = tbl[i].ld; data = tbl[i].d; op = tbl[i].o; step = tbl[i].st;
      start = tbl[i].go; count = tbl[i].cnt; SinL = tbl[i].sl; SinR = tbl[i].sr;
      tick();
      check($sformatf("vec%0d out", i), out, tbl[i].e_out);
      check($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
      check($sformatf("vec%0d done", i), done, tbl[i].e_done);
    end
    idle_inputs();

    // Reset in the 3rd RUN cycle of a 9-step burst, then a fresh burst
    Load = 1'b1; data = 8'h55; tick(); Load = 1'b0;
    start = 1'b1; op = 3'd1; count = 4'd9; tick(); start = 1'b0;
    check("rst-mid busy", busy, 1);
    tick(); check("rst-mid run1", out, 8'hAA);
    tick(); check("rst-mid run2", out, 8'h54);
    RST = 1'b1; tick(); RST = 1'b0;
    check("rst-mid out", out, 0);
    check("rst-mid busy0", busy, 0);
    check("rst-mid done0", done, 0);
    start = 1'b1; op = 3'd1; count = 4'd2; SinL = 1'b1; tick(); start = 1'b0;
    check("post-rst busy", busy, 1);
    tick(); check("post-rst s1", out, 8'h01);
    tick(); check("post-rst s2", out, 8'h03);
    check("post-rst done", done, 1);
    check("post-rst busy0", busy, 0);
    idle_inputs();

    // Load aborts a ROR burst on its 2nd RUN edge
    Load = 1'b1; data = 8'h01; tick(); Load = 1'b0;
    start = 1'b1; op = 3'd4; count = 4'd5; tick(); start = 1'b0;
    tick(); check("abort run1", out, 8'h80);
    Load = 1'b1; data = 8'hAA; tick(); Load = 1'b0;
    check("abort out", out, 8'hAA);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    tick();
    check("abort no done", done, 0);
    check("abort hold", out, 8'hAA);
    idle_inputs();

    // op 101 burst
`ifdef ARITH_SHIFT_EN
    exp6 = 8'hF0;
`else
    exp6 = 8'h80;
`endif
    Load = 1'b1; data = 8'h80; tick(); Load = 1'b0;
    start = 1'b1; op = 3'd5; count = 4'd3; SinR = 1'b0; tick(); start = 1'b0;
    tick(); check("op5 busy1", busy, 1);
    tick(); check("op5 busy2", busy, 1);
    tick();
    check("op5 out", out, exp6);
    check("op5 done", done, 1);
    check("op5 busy0", busy, 0);
    tick(); check("op5 done off", done, 0);
    idle_inputs();

    // 16-bit, 4-bit step instance
    data16 = 16'h1234; load16 = 1'b1; tick(); load16 = 1'b0;
    step16 = 1'b1; op16 = 3'd3; tick();
    check("w16 rol", out16, 16'h2341);
    op16 = 3'd2; sinr16 = 4'hF; tick(); step16 = 1'b0;
    check("w16 shr", out16, 16'hF234);
    check("w16 soutL", soutl16, 4'hF);
    check("w16 soutR", soutr16, 4'h4);
    check("w16 busy", busy16, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      RST   = (c == 0) || ($urandom_range(0, 99) == 0);
      Load  = ($urandom_range(0, 15) == 0);
      data  = 8'($urandom);
      op    = 3'($urandom);
      step  = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 5) == 0);
      count = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
      SinL  = 1'($urandom);
      SinR  = 1'($urandom);
      model_edge();
      tick();
      check("rnd out", out, m_out);
      check("rnd busy", busy, (m_left > 0) ? 1 : 0);
      check("rnd done", done, m_done);
      check("rnd soutL", soutL, (m_out >> (B - 1)) & 1);
      check("rnd soutR", soutR, m_out & 1);
    end
    RST = 1'b0;
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
